uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, is the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, is the serial bit rate.
REQ-003 i_clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_rx  input  1  asynchronous serial line; idle high.
REQ-006 o_data  output  8  last correctly framed received byte.
REQ-007 o_rx_valid  output  1  one-cycle pulse when o_data is updated.
REQ-008 o_rx_busy  output  1  high while a frame is in progress.
REQ-009 o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-011 CPB = CLK_FREQ/BAUD_RATE and HALF = CPB/2 (integer); CPB < 4 SHALL be a static elaboration error.
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; "line" below means the synchronized value.
REQ-013 Bit timer width SHALL be $clog2(CPB); the timer resets to 0 on every state transition.
REQ-014 States: IDLE, START, DATA, [PARITY], STOP, BREAK; o_rx_busy = (state != IDLE).
REQ-015 IDLE: when line = 0, go to START.
REQ-016 START: at timer = HALF-1, sample line; if 0, go to DATA; if 1 (glitch), return to IDLE with no output pulse.
REQ-017 DATA: every CPB cycles, measured from the mid-start sample, sample line into an 8-bit shift register, LSB first; after the 8th sample, go to PARITY (if compiled in), else go to STOP.
REQ-018 STOP: at timer = CPB-1, sample line.
REQ-019 Stop sample = 1: o_data <= shift register and o_rx_valid = 1 for exactly one cycle; go to IDLE.
REQ-020 Stop sample = 0: o_frame_err = 1 for one cycle; o_data is unchanged and o_rx_valid stays 0; go to BREAK.
REQ-021 BREAK: remain until line = 1, then go to IDLE, so a held-low line produces exactly one o_frame_err.
REQ-022 A new start bit SHALL be recognised in the cycle after the return to IDLE, so back-to-back frames with one stop bit are received without loss.
REQ-023 o_data SHALL hold its value between valid pulses; i_rx activity outside a frame SHALL NOT disturb it.
REQ-024 o_rx_valid, o_frame_err and o_parity_err SHALL never pulse in the same cycle, except o_rx_valid with o_parity_err.

Reset
REQ-025 While i_rst = 1 at a clock edge, the block SHALL set: state IDLE, timer 0, bit count 0, shift register 0x00, o_data 0x00, all pulses 0, o_rx_busy 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no pulse; reception resumes at the next falling edge after reset release.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, a PARITY state follows DATA.
REQ-028 The PARITY state samples one even-parity bit at CPB-1, then goes to STOP.
REQ-029 On a good stop bit, o_rx_valid pulses and o_parity_err pulses in the same cycle if the XOR of the data and parity bits is 1.
REQ-030 With UART_RX_PARITY_EN undefined, the block has no PARITY state, the frame is 10 bits, and o_parity_err is tied to 0; the port list is identical in both builds.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CPB=10)
REQ-031 Reset, then frame 0xA5 (start, 10100101 LSB-first, stop) -> a single o_rx_valid pulse with o_data=0xA5; o_frame_err=0; o_rx_busy low after the pulse.
REQ-032 Frames 0x00, then 0xFF, back-to-back with one stop bit each -> two valid pulses carrying 0x00 then 0xFF.
REQ-033 i_rx low for 3 cycles, then high -> no pulse; state back to IDLE; o_data unchanged.
REQ-034 Frame 0x3C with stop bit low, line held low for 40 cycles, then high -> exactly one o_frame_err; no o_rx_valid; o_data keeps its prior value; next frame 0x11 is received correctly.
REQ-035 i_rst asserted for 1 cycle during data bit 4 of 0x5A -> no pulse; all outputs at reset values; a following frame 0x5A is received.
REQ-036 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid pulse, o_parity_err=0; 0x07 with parity bit 0 -> valid pulse with o_parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling.
// Latency: 2-cycle input synchronizer; the result pulse appears 1 cycle after the mid-stop sample.
// Backpressure: none; each result is a single-cycle pulse and o_data holds until the next good frame.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_parity_err
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] CPB_M1  = TW'(CPB - 1);

    // Fewer than 4 clocks per bit leaves no room to find the bit centre.
    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_meta;
    logic            line;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            timer_clr;
    logic            shift_en;
    logic            load_data;
    logic            frame_bad;
`ifdef UART_RX_PARITY_EN
    logic            par_en;
    logic            par_bit;
    logic            parity_err;
`endif

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            line    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            line    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit timer: restarts on every transition and after each data-bit sample.
    always_ff @(posedge i_clk) begin
        if (i_rst || timer_clr) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (!line) state_nxt = S_START;
            end
            S_START: begin
                if (timer == HALF_M1) begin
                    timer_clr = 1'b1;
                    state_nxt = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer == CPB_M1) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'd7) state_nxt = S_PARITY;
`else
                    if (bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer == CPB_M1) begin
                    timer_clr = 1'b1;
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (timer == CPB_M1) begin
                    timer_clr = 1'b1;
                    if (line) begin
                        load_data = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                timer_clr = 1'b1;
                if (line) state_nxt = S_IDLE;
            end
            default: begin
                timer_clr = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register, bit counter, output byte and result pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift       <= 8'h00;
            bit_cnt     <= 3'd0;
            o_data      <= 8'h00;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (shift_en) begin
                shift   <= {line, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (load_data) o_data <= shift;
            o_rx_valid  <= load_data;
            o_frame_err <= frame_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be 0; reported only with a good stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) par_bit <= line;
            parity_err <= load_data & ((^shift) ^ par_bit);
        end
    end
    assign o_parity_err = parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level reference model with a pulse scoreboard.
// Latency: expectations are queued at frame start and popped by the monitor on any result pulse.
// Backpressure: none; the monitor also checks o_data holds its last good value between pulses.
module tb_uart_rx;
    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        bit         vld;
        bit         ferr;
        bit         perr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_valid;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       o_parity_err;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_data = 8'h00;
    int         compared = 0;
    int         mismatched = 0;

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_valid  (o_rx_valid),
        .o_rx_busy   (o_rx_busy),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: pop one expectation per result pulse; otherwise o_data must hold.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_rx_valid || o_frame_err || o_parity_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({o_rx_valid, o_frame_err, o_parity_err}), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid", 32'(o_rx_valid), 32'(mon_e.vld));
                    check("frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
                    check("parity_err", 32'(o_parity_err), 32'(mon_e.perr));
                    if (mon_e.vld) begin
                        check("data", 32'(o_data), 32'(mon_e.data));
                        check("busy_at_valid", 32'(o_rx_busy), 32'(0));
                        model_data = mon_e.data;
                    end else begin
                        check("data_kept_on_err", 32'(o_data), 32'(model_data));
                    end
                end
            end else begin
                check("data_hold", 32'(o_data), 32'(model_data));
            end
        end
    end

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // One frame on the line; the expected outcome follows from the stop and parity bits alone.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int low_extra);
        exp_t e;
        e.vld  = stop;
        e.ferr = !stop;
        e.perr = PAR_BUILD && stop && ((^d) ^ par);
        e.data = d;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_BUILD) drive_bit(par);
        drive_bit(stop);
        if (!stop) begin
            i_rx = 1'b0;
            repeat (low_extra) @(negedge clk);
            idle(4);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] d;
        bit         stop;
        bit         par;
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(o_data), 32'(0));
        check("rst_busy", 32'(o_rx_busy), 32'(0));
        check("rst_valid", 32'(o_rx_valid), 32'(0));
        check("rst_ferr", 32'(o_frame_err), 32'(0));
        check("rst_perr", 32'(o_parity_err), 32'(0));
        i_rst = 1'b0;
        idle(5);

        // Single good frame.
        send_frame(8'hA5, 1'b1, ^8'hA5, 0);
        wait_drain(200);
        idle(3);
        check("busy_after_a5", 32'(o_rx_busy), 32'(0));

        // Back-to-back frames, one stop bit each.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        wait_drain(200);
        idle(5);

        // Short glitch: no frame, back to idle, o_data unchanged.
        i_rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("glitch_busy", 32'(o_rx_busy), 32'(0));
        check("glitch_data", 32'(o_data), 32'(8'hFF));
        check("glitch_no_pulse", 32'(exp_q.size()), 32'(0));

        // Bad stop bit followed by a long break, then a good frame.
        send_frame(8'h3C, 1'b0, ^8'h3C, 40);
        send_frame(8'h11, 1'b1, ^8'h11, 0);
        wait_drain(200);
        idle(5);

        // Reset pulse in the middle of data bit 4 abandons the frame.
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        i_rx = d[4];
        repeat (CPB / 2) @(negedge clk);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        @(negedge clk);
        model_data = 8'h00;
        i_rst = 1'b0;
        check("midrst_data", 32'(o_data), 32'(0));
        check("midrst_busy", 32'(o_rx_busy), 32'(0));
        check("midrst_valid", 32'(o_rx_valid), 32'(0));
        check("midrst_ferr", 32'(o_frame_err), 32'(0));
        idle(2 * CPB);
        send_frame(8'h5A, 1'b1, ^8'h5A, 0);
        wait_drain(200);
        idle(5);

        // Parity good and bad (parity build only).
        if (PAR_BUILD) begin
            send_frame(8'h07, 1'b1, 1'b1, 0);
            send_frame(8'h07, 1'b1, 1'b0, 0);
            wait_drain(300);
            idle(5);
        end

        // Randomized frames with random gaps, stop bits and parity bits.
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            par  = 1'($urandom_range(0, 1));
            send_frame(d, stop, par, stop ? 0 : int'($urandom_range(0, 30)));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 25)));
        end

        wait_drain(500);
        idle(10);
        check("final_busy", 32'(o_rx_busy), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
